// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Multi-channel LED pattern generator. Each of CHANNELS outputs can be set
// OFF, ON, BLINK (half-period of rate+1 ticks) or PWM (duty = low DUTY_W bits
// of rate, out of 2^DUTY_W). A prescaler makes a one-cycle tick enable every
// CLK_DIV cycles, so everything runs on mclk with no derived clocks.
//
// Ports:
//   mclk      in            system clock, rising edge
//   rs        in            asynchronous active-low reset
//   cfg_we    in            config write strobe
//   cfg_ch    in  CH_W      target channel of the write
//   cfg_mode  in  2         00 OFF, 01 ON, 10 BLINK, 11 PWM
//   cfg_rate  in  RATE_W    BLINK: half-period-1 in ticks; PWM: low bits = duty
//   sync      in            one-cycle pulse, realigns prescaler and blink phases
//   cfg_ack   out           one-cycle pulse, write accepted
//   cfg_err   out           one-cycle pulse, write to nonexistent channel
//   led       out CHANNELS  registered LED drive, bit i = channel i
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int CLK_DIV  = 25000,
  parameter int RATE_W   = 8,
  parameter int DUTY_W   = 4
) (
  input  logic                mclk,
  input  logic                rs,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [RATE_W-1:0]   cfg_rate,
  input  logic                sync,
  output logic                cfg_ack,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  localparam int              PRE_W    = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0]    pre_cnt_reg;
  logic [PRE_W-1:0]    pre_cnt_next;
  logic                tick;
  logic [DUTY_W-1:0]   pwm_cnt_reg;
  logic                ch_valid;
  logic                ack_next;
  logic                err_next;
  logic                ack_reg;
  logic                err_reg;
  logic [CHANNELS-1:0] led_reg;
  logic [CHANNELS-1:0] led_next;

  // ---------------------------------------------------------------------------
  // Prescaler: tick is high for the single cycle where the count sits at
  // CLK_DIV-1. sync restarts the count, which also suppresses a tick that
  // would otherwise land on the same edge.
  // ---------------------------------------------------------------------------
  assign tick = (pre_cnt_reg == PRE_LAST);

  always_comb begin
    pre_cnt_next = pre_cnt_reg + PRE_W'(1);
    if (sync || tick) begin
      pre_cnt_next = '0;
    end
  end

  // Channel indices that exist are accepted; anything above is rejected
  // without touching any channel state.
  assign ch_valid = (32'(cfg_ch) < 32'(CHANNELS));
  assign ack_next = cfg_we & ch_valid;
  assign err_next = cfg_we & ~ch_valid;

  always_ff @(posedge mclk or negedge rs) begin
    if (!rs) begin
      pre_cnt_reg <= '0;
      pwm_cnt_reg <= '0;
      led_reg     <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
      pwm_cnt_reg <= pwm_cnt_reg + DUTY_W'(1);  // free-running, shared by all
      led_reg     <= led_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel state. Priority on a given edge: a write to this channel,
  // then sync (or a non-BLINK mode) clearing phase/bstate, then a tick
  // advancing the blink phase.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      mode_t             mode_reg;
      mode_t             mode_next;
      logic [RATE_W-1:0] rate_reg;
      logic [RATE_W-1:0] rate_next;
      logic [RATE_W-1:0] phase_reg;
      logic [RATE_W-1:0] phase_next;
      logic              bstate_reg;
      logic              bstate_next;
      logic              wr_hit;
      logic              led_bit;

      assign wr_hit = cfg_we && ch_valid && (cfg_ch == CH_W'(gi));

      always_comb begin
        mode_next   = mode_reg;
        rate_next   = rate_reg;
        phase_next  = phase_reg;
        bstate_next = bstate_reg;
        if (wr_hit) begin
          mode_next   = mode_t'(cfg_mode);
          rate_next   = cfg_rate;
          phase_next  = '0;
          bstate_next = 1'b0;
        end else if (sync || (mode_reg != MODE_BLINK)) begin
          phase_next  = '0;
          bstate_next = 1'b0;
        end else if (tick) begin
          if (phase_reg == rate_reg) begin
            phase_next  = '0;
            bstate_next = ~bstate_reg;
          end else begin
            phase_next  = phase_reg + RATE_W'(1);
          end
        end
      end

      // LED drive is decided from the mode already in effect, so a new mode
      // shows on the edge after the write that loaded it.
      always_comb begin
        led_bit = 1'b0;
        case (mode_reg)
          MODE_OFF:   led_bit = 1'b0;
          MODE_ON:    led_bit = 1'b1;
          MODE_BLINK: led_bit = bstate_reg;
          MODE_PWM:   led_bit = (pwm_cnt_reg < rate_reg[DUTY_W-1:0]);
          default:    led_bit = 1'b0;
        endcase
      end

      assign led_next[gi] = led_bit;

      always_ff @(posedge mclk or negedge rs) begin
        if (!rs) begin
          mode_reg   <= MODE_OFF;
          rate_reg   <= '0;
          phase_reg  <= '0;
          bstate_reg <= 1'b0;
        end else begin
          mode_reg   <= mode_next;
          rate_reg   <= rate_next;
          phase_reg  <= phase_next;
          bstate_reg <= bstate_next;
        end
      end
    end
  endgenerate

  assign cfg_ack = ack_reg;
  assign cfg_err = err_reg;
  assign led     = led_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Scoreboard bench for led_pattern_gen (CHANNELS=3, CLK_DIV=4, DUTY_W=4).
// Stimulus pushes expected LED values (stamped with the cycle they must
// appear) and expected ack/err responses into queues; a monitor on the
// falling edge pops and compares. PWM duty is checked by counting high
// cycles over whole PWM periods.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;
  localparam int CLK_DIV  = 4;
  localparam int RATE_W   = 8;
  localparam int DUTY_W   = 4;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_PWM   = 2'b11;

  logic                mclk     = 1'b0;
  logic                rs       = 1'b0;
  logic                cfg_we   = 1'b0;
  logic [CH_W-1:0]     cfg_ch   = '0;
  logic [1:0]          cfg_mode = '0;
  logic [RATE_W-1:0]   cfg_rate = '0;
  logic                sync     = 1'b0;
  logic                cfg_ack;
  logic                cfg_err;
  logic [CHANNELS-1:0] led;

  typedef struct {
    int         at;
    logic [2:0] val;
    string      tag;
  } led_exp_t;

  typedef struct {
    int         at;
    logic [1:0] kind;   // {ack, err}
  } resp_exp_t;

  led_exp_t  led_q[$];
  resp_exp_t resp_q[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  led_pattern_gen #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W),
    .CLK_DIV  (CLK_DIV),
    .RATE_W   (RATE_W),
    .DUTY_W   (DUTY_W)
  ) dut (
    .mclk     (mclk),
    .rs       (rs),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_rate (cfg_rate),
    .sync     (sync),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .led      (led)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic push_led(input int at, input logic [2:0] val, input string tag);
    led_exp_t e;
    e.at  = at;
    e.val = val;
    e.tag = tag;
    led_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Called on a falling edge; the write lands on the next rising edge E,
  // whose response must be visible at the falling edge of cycle E.
  task automatic do_write(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [7:0] rate, input bit ok, input bit with_sync);
    resp_exp_t r;
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = mode;
    cfg_rate = rate;
    sync     = with_sync;
    r.at     = cyc + 1;
    r.kind   = ok ? 2'b10 : 2'b01;
    resp_q.push_back(r);
    $display("write ch=%0d mode=%0d rate=%0d sync=%0d edge=%0d", ch, mode, rate, with_sync, r.at);
    @(negedge mclk);
    cfg_we = 1'b0;
    sync   = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge mclk) begin
    led_exp_t  le;
    resp_exp_t re;
    while (led_q.size() > 0 && led_q[0].at <= cyc) begin
      le = led_q.pop_front();
      if (le.at == cyc) chk({"led_", le.tag}, int'(led), int'(le.val));
    end
    if (cfg_ack || cfg_err) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", int'({cfg_ack, cfg_err}), 0);
      end else begin
        re = resp_q.pop_front();
        chk("resp_cycle", cyc, re.at);
        chk("resp_kind", int'({cfg_ack, cfg_err}), int'(re.kind));
        $display("resp ack=%0d err=%0d cycle=%0d", cfg_ack, cfg_err, cyc);
      end
    end else if (resp_q.size() > 0 && resp_q[0].at < cyc) begin
      re = resp_q.pop_front();
      chk("resp_missing", int'({cfg_ack, cfg_err}), int'(re.kind));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int other;

    // ---------------- reset state ----------------
    idle(3);
    chk("reset_led", int'(led), 0);
    chk("reset_ack", int'(cfg_ack), 0);
    chk("reset_err", int'(cfg_err), 0);
    rs = 1'b1;
    idle(2);

    // ---------------- ON / OFF on ch2 ----------------
    n = cyc;
    push_led(n + 1, 3'b000, "on_edge");
    push_led(n + 2, 3'b100, "on");
    push_led(n + 3, 3'b100, "on");
    do_write(2'd2, M_ON, 8'd0, 1'b1, 1'b0);
    idle(2);
    n = cyc;
    push_led(n + 1, 3'b100, "off_edge");
    push_led(n + 2, 3'b000, "off");
    push_led(n + 3, 3'b000, "off");
    do_write(2'd2, M_OFF, 8'd0, 1'b1, 1'b0);
    idle(3);

    // ---------------- back-to-back writes ----------------
    n = cyc;
    push_led(n + 1, 3'b000, "b2b");
    push_led(n + 2, 3'b001, "b2b");
    push_led(n + 3, 3'b011, "b2b");
    push_led(n + 4, 3'b011, "b2b");
    do_write(2'd0, M_ON, 8'd0, 1'b1, 1'b0);
    do_write(2'd1, M_ON, 8'd0, 1'b1, 1'b0);
    idle(3);
    n = cyc;
    push_led(n + 2, 3'b010, "b2b_off");
    push_led(n + 3, 3'b000, "b2b_off");
    do_write(2'd0, M_OFF, 8'd0, 1'b1, 1'b0);
    do_write(2'd1, M_OFF, 8'd0, 1'b1, 1'b0);
    idle(3);

    // ---------------- invalid channel ----------------
    do_write(2'd2, M_ON, 8'd0, 1'b1, 1'b0);
    idle(2);
    n = cyc;
    for (int k = 1; k <= 5; k++) push_led(n + k, 3'b100, "invalid");
    do_write(2'd3, M_OFF, 8'd0, 1'b0, 1'b0);
    idle(5);
    do_write(2'd2, M_OFF, 8'd0, 1'b1, 1'b0);
    idle(2);

    // ---------------- PWM on ch1, two full periods each ----------------
    do_write(2'd1, M_PWM, 8'd5, 1'b1, 1'b0);
    cnt = 0;
    repeat (32) begin
      @(negedge mclk);
      cnt += int'(led[1]);
    end
    chk("pwm_duty5_high", cnt, 10);

    do_write(2'd1, M_PWM, 8'd0, 1'b1, 1'b0);
    cnt = 0;
    repeat (32) begin
      @(negedge mclk);
      cnt += int'(led[1]);
    end
    chk("pwm_duty0_high", cnt, 0);

    do_write(2'd1, M_PWM, 8'd15, 1'b1, 1'b0);
    cnt   = 0;
    other = 0;
    repeat (32) begin
      @(negedge mclk);
      cnt   += int'(led[1]);
      other += int'(led[0] | led[2]);
    end
    chk("pwm_duty15_high", cnt, 30);
    chk("pwm_other_bits", other, 0);
    do_write(2'd1, M_OFF, 8'd0, 1'b1, 1'b0);
    idle(2);

    // ---------------- BLINK ch0 rate=2, write+sync together ----------------
    // Ticks at E+4k; toggles on the 3rd tick -> 12 cycles low, 12 high.
    n = cyc;
    push_led(n + 1, 3'b000, "blink");
    for (int k = 1; k <= 48; k++)
      push_led(n + 1 + k, ((((k - 1) / 12) % 2) == 1) ? 3'b001 : 3'b000, "blink");
    do_write(2'd0, M_BLINK, 8'd2, 1'b1, 1'b1);
    idle(50);

    // ---------------- sync realignment ----------------
    do_write(2'd0, M_BLINK, 8'd1, 1'b1, 1'b0);
    idle(4);
    do_write(2'd1, M_BLINK, 8'd1, 1'b1, 1'b0);
    idle(7);
    // sync at edge S; a second sync at S+20 coincides with a tick.
    n = cyc;
    for (int k = 1; k <= 44; k++)
      push_led(n + 1 + k,
               (((k >= 9) && (k <= 16)) || ((k >= 29) && (k <= 36))) ? 3'b011 : 3'b000,
               "sync");
    sync = 1'b1;
    $display("sync edge=%0d", cyc + 1);
    @(negedge mclk);
    sync = 1'b0;
    idle(19);
    sync = 1'b1;
    $display("sync edge=%0d", cyc + 1);
    @(negedge mclk);
    sync = 1'b0;
    idle(26);

    // ---------------- asynchronous reset mid-pattern ----------------
    do_write(2'd1, M_OFF, 8'd0, 1'b1, 1'b0);
    idle(2);
    n = cyc;
    for (int k = 2; k <= 5; k++) push_led(n + k, 3'b000, "rst_pre");
    push_led(n + 6, 3'b001, "rst_pre");
    do_write(2'd0, M_BLINK, 8'd0, 1'b1, 1'b1);
    idle(6);
    chk("prereset_led", int'(led), 1);
    #2;
    rs = 1'b0;
    #1;
    chk("async_reset_led", int'(led), 0);
    chk("async_reset_ack", int'(cfg_ack), 0);
    chk("async_reset_err", int'(cfg_err), 0);
    idle(2);
    rs = 1'b1;
    n = cyc;
    for (int k = 1; k <= 16; k++) push_led(n + k, 3'b000, "post_reset");
    idle(18);

    chk("led_queue_drained", led_q.size(), 0);
    chk("resp_queue_drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED pattern generator: successor to the single-LED flasher. Drives `CHANNELS` LED outputs, each independently configurable as off, on, blink at a programmable rate, or PWM-dimmed. A built-in prescaler produces a one-cycle tick enable in place of a derived clock, so all logic runs on `mclk`. The block sits between the board-level control logic (config writes) and the LED pins.

## Interface

Parameters:
- `CHANNELS`, 4: number of LED channels, 1..16.
- `CH_W`, 2: width of `cfg_ch`, 2^CH_W >= CHANNELS.
- `CLK_DIV`, 25000: mclk cycles per tick, 2..65536.
- `RATE_W`, 8: width of `cfg_rate` and per-channel phase counter.
- `DUTY_W`, 4: PWM resolution, DUTY_W <= RATE_W.

Ports:
- `mclk` in 1: system clock, all logic on rising edge.
- `rs` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: config write strobe, sampled each `mclk` edge.
- `cfg_ch` in CH_W: target channel.
- `cfg_mode` in 2: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
- `cfg_rate` in RATE_W: BLINK half-period minus 1 in ticks; in PWM, low DUTY_W bits = duty.
- `sync` in 1: one-cycle pulse, realigns all blink phases.
- `cfg_ack` out 1: one-cycle pulse, write accepted.
- `cfg_err` out 1: one-cycle pulse, write rejected (`cfg_ch` >= CHANNELS).
- `led` out CHANNELS: registered LED drive, bit i = channel i.

## Operation

- Reset (`rs` low, asynchronous): all modes OFF, all rates 0, phase counters 0, blink states 0, prescaler 0, PWM counter 0, `led`=0, `cfg_ack`=0, `cfg_err`=0. Reset asserted mid-operation overrides everything immediately.
- Prescaler: counts 0..CLK_DIV-1, wraps to 0; `tick` is high for the one cycle where count = CLK_DIV-1.
- PWM counter: DUTY_W-bit free-running, increments every `mclk`, wraps 2^DUTY_W-1 -> 0; shared by all channels.
- Per channel i: `mode`, `rate`, `phase` (RATE_W bits), `bstate` (1 bit).
- OFF: next `led[i]`=0. ON: next `led[i]`=1.
- BLINK: on each tick, if `phase` == `rate` then `phase`<=0 and `bstate` toggles, else `phase` increments. Next `led[i]` = `bstate`. Half-period = (rate+1) ticks; rate=0 toggles every tick.
- PWM: next `led[i]` = (pwm_cnt < rate[DUTY_W-1:0]). duty 0 = always off; maximum duty is (2^DUTY_W-1)/2^DUTY_W, never 100% (use ON for that).
- `phase` and `bstate` only advance in BLINK mode; held at 0 in other modes.
- Config write: when `cfg_we`=1 and `cfg_ch` < CHANNELS, at that edge E the channel's `mode`/`rate` load, `phase`<=0, `bstate`<=0, `cfg_ack`<=1 for one cycle. When `cfg_ch` >= CHANNELS: no state change, `cfg_err`<=1 for one cycle. Back-to-back writes on consecutive cycles are accepted, one ack each.
- `sync`=1: prescaler, all `phase` and all `bstate` cleared at that edge; modes/rates unchanged.
- Simultaneous events: a write and a tick to the same channel: write wins (phase=0, bstate=0). `sync` and a write in the same cycle: both apply. `sync` and a tick in the same cycle: `sync` wins, no phase advance.

## Timing

- Write at edge E: `cfg_ack`/`cfg_err` high in cycle E..E+1; `led[i]` reflects the new mode from edge E+1.
- Blink: after write at E, the first `bstate` toggle occurs on the (rate+1)th tick after E; `led` follows one edge later.
- `tick` latency: first tick occurs CLK_DIV cycles after reset release or `sync`.
- `led` is always a register output; no combinational path from inputs to `led`.

## Test plan

- Reset: CHANNELS=4, ch0 BLINK rate=0, CLK_DIV=4; drive `rs` low mid-pattern -> `led`=0000 immediately; release -> `led` stays 0000, no ack.
- ON/OFF: write ch2 mode=01 -> `cfg_ack` one cycle, `led`=0100 from edge E+1; write ch2 mode=00 -> `led`=0000 one edge later.
- Blink: CLK_DIV=4, ch0 BLINK rate=2 -> `led[0]` low 12 cycles, high 12 cycles, period 24, repeating.
- PWM: DUTY_W=4, ch1 PWM rate=5 -> `led[1]` high exactly 5 of every 16 cycles; rate=0 -> never high; rate=15 -> high 15/16.
- Invalid channel: CHANNELS=3, write `cfg_ch`=3 -> `cfg_err` pulse, no `cfg_ack`, all channel states unchanged.
- Sync: ch0 and ch1 BLINK rate=1 written 5 cycles apart; pulse `sync` -> `led[0]` and `led[1]` toggle on identical cycles thereafter; `sync` coincident with a tick -> no phase advance.
